// File: rtl/pulp_rst_sequencer.sv
// Board reset sequencer: synchronizes button/TRST/lock, debounces the button, then releases the
// off-chip peripheral reset and later the SoC reset. Optional lock timeout: PULP_RST_LOCK_TIMEOUT_EN.
module pulp_rst_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES     = 16,
   parameter int unsigned PERIPH_HOLD_CYCLES  = 64,
   parameter int unsigned CORE_DELAY_CYCLES   = 32,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096
) (
   input  logic       ref_clk,
   input  logic       reset,
   input  logic       pad_reset_i,
   input  logic       jtag_trst_n_i,
   input  logic       mmcm_locked_i,
   output logic       periph_reset_n_o,
   output logic       pulp_reset_n_o,
   output logic [2:0] state_o,
   output logic [1:0] rst_cause_o,
   output logic       lock_err_o
);

   typedef enum logic [2:0] {
      StHold     = 3'd0,
      StWaitLock = 3'd1,
      StPeriph   = 3'd2,
      StCore     = 3'd3,
      StRun      = 3'd4
   } state_e;

   localparam int unsigned MaxSeq = (PERIPH_HOLD_CYCLES > CORE_DELAY_CYCLES) ?
                                    PERIPH_HOLD_CYCLES : CORE_DELAY_CYCLES;
`ifdef PULP_RST_LOCK_TIMEOUT_EN
   localparam int unsigned MaxCnt = (MaxSeq > LOCK_TIMEOUT_CYCLES) ? MaxSeq : LOCK_TIMEOUT_CYCLES;
`else
   localparam int unsigned MaxCnt = MaxSeq;
`endif
   localparam int unsigned CntW = $clog2(MaxCnt + 1);
   localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);

   // Zero-length phases would make the terminal-count compares underflow.
   if (DEBOUNCE_CYCLES < 1 || PERIPH_HOLD_CYCLES < 1 || CORE_DELAY_CYCLES < 1 ||
       LOCK_TIMEOUT_CYCLES < 1) begin : gen_param_check
      $error("pulp_rst_sequencer: all cycle parameters must be at least 1");
   end

   logic [1:0]      pad_sync_q, trst_sync_q, lock_sync_q;
   logic            btn_s, trst_n_s, lock_s;
   logic [DbW-1:0]  db_cnt_q, db_cnt_d;
   logic            btn_db_q, btn_db_d;
   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      cause_q, cause_d;
   logic            periph_n_q, periph_n_d;
   logic            pulp_n_q, pulp_n_d;
   logic            req_base, req_lock;

   assign btn_s    = pad_sync_q[1];
   assign trst_n_s = trst_sync_q[1];
   assign lock_s   = lock_sync_q[1];

   always_ff @(posedge ref_clk) begin
      if (reset) begin
         pad_sync_q  <= '0;
         trst_sync_q <= '0;
         lock_sync_q <= '0;
         db_cnt_q    <= '0;
         btn_db_q    <= 1'b0;
         state_q     <= StHold;
         cnt_q       <= '0;
         cause_q     <= 2'b00;
         periph_n_q  <= 1'b0;
         pulp_n_q    <= 1'b0;
      end else begin
         pad_sync_q  <= {pad_sync_q[0], pad_reset_i};
         trst_sync_q <= {trst_sync_q[0], jtag_trst_n_i};
         lock_sync_q <= {lock_sync_q[0], mmcm_locked_i};
         db_cnt_q    <= db_cnt_d;
         btn_db_q    <= btn_db_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cause_q     <= cause_d;
         periph_n_q  <= periph_n_d;
         pulp_n_q    <= pulp_n_d;
      end
   end

   // Count consecutive cycles the synced button disagrees with the debounced value.
   always_comb begin
      db_cnt_d = '0;
      btn_db_d = btn_db_q;
      if (btn_s != btn_db_q) begin
         if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_d = btn_s;
         end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
         end
      end
   end

`ifdef PULP_RST_LOCK_TIMEOUT_EN
   logic lock_err_q, lock_err_d;

   always_ff @(posedge ref_clk) begin
      if (reset) lock_err_q <= 1'b0;
      else       lock_err_q <= lock_err_d;
   end

   assign lock_err_o = lock_err_q;
`else
   assign lock_err_o = 1'b0;
`endif

   assign req_base = btn_db_q | ~trst_n_s;
   assign req_lock = ~lock_s;

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      cause_d = cause_q;
`ifdef PULP_RST_LOCK_TIMEOUT_EN
      lock_err_d = lock_err_q;
`endif
      case (state_q)
         StHold: begin
            if (!btn_db_q && trst_n_s) state_d = StWaitLock;
         end
         StWaitLock: begin
            if (req_base) begin
               state_d = StHold;
            end else if (lock_s) begin
               state_d = StPeriph;
`ifdef PULP_RST_LOCK_TIMEOUT_EN
            end else if (cnt_q == CntW'(LOCK_TIMEOUT_CYCLES - 1)) begin
               state_d    = StHold;
               lock_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
`endif
            end
         end
         StPeriph: begin
            if (req_base || req_lock) begin
               state_d = StHold;
            end else if (cnt_q == CntW'(PERIPH_HOLD_CYCLES - 1)) begin
               state_d = StCore;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StCore: begin
            if (req_base || req_lock) begin
               state_d = StHold;
            end else if (cnt_q == CntW'(CORE_DELAY_CYCLES - 1)) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRun: begin
            if (req_base || req_lock) state_d = StHold;
         end
         default: state_d = StHold;
      endcase

      // Timeout in WAIT_LOCK falls through to the lock-loss code.
      if (state_q != StHold && state_d == StHold) begin
         if (!trst_n_s)     cause_d = 2'b10;
         else if (btn_db_q) cause_d = 2'b01;
         else               cause_d = 2'b11;
      end

      periph_n_d = (state_d == StCore) || (state_d == StRun);
      pulp_n_d   = (state_d == StRun);
   end

   assign periph_reset_n_o = periph_n_q;
   assign pulp_reset_n_o   = pulp_n_q;
   assign state_o          = state_q;
   assign rst_cause_o      = cause_q;

endmodule

// File: tb/tb_pulp_rst_sequencer.sv
// Bench for pulp_rst_sequencer: directed scenarios plus random input traffic, every cycle compared
// against a time-stamp based reference model.
module tb_pulp_rst_sequencer;

   localparam int unsigned Deb = 16;
   localparam int unsigned Ph  = 64;
   localparam int unsigned Cd  = 32;
   localparam int unsigned Lt  = 4096;
`ifdef PULP_RST_LOCK_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   logic       ref_clk = 1'b0;
   logic       reset = 1'b1;
   logic       pad = 1'b0;
   logic       trst_n = 1'b1;
   logic       lock = 1'b0;
   logic       periph_n, pulp_n, lock_err;
   logic [2:0] state;
   logic [1:0] cause;

   pulp_rst_sequencer #(
      .DEBOUNCE_CYCLES    (Deb),
      .PERIPH_HOLD_CYCLES (Ph),
      .CORE_DELAY_CYCLES  (Cd),
      .LOCK_TIMEOUT_CYCLES(Lt)
   ) dut (
      .ref_clk         (ref_clk),
      .reset           (reset),
      .pad_reset_i     (pad),
      .jtag_trst_n_i   (trst_n),
      .mmcm_locked_i   (lock),
      .periph_reset_n_o(periph_n),
      .pulp_reset_n_o  (pulp_n),
      .state_o         (state),
      .rst_cause_o     (cause),
      .lock_err_o      (lock_err)
   );

   always #5 ref_clk = ~ref_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: sync stages as delayed copies, debounce as a sliding window of samples,
   // state dwell as elapsed edges since entry.
   int cyc = 0;
   int m_state = 0;
   int enter = 0;
   int m_cause = 0;
   bit m_err = 1'b0;
   bit p_s1, p_s2, t_s1, t_s2, l_s1, l_s2, db;
   bit hist[$];

   function automatic void model_clear();
      m_state = 0; enter = cyc; m_cause = 0; m_err = 1'b0; db = 1'b0;
      {p_s1, p_s2, t_s1, t_s2, l_s1, l_s2} = '0;
      hist.delete();
      for (int i = 0; i < int'(Deb); i++) hist.push_back(1'b0);
   endfunction

   function automatic void model_edge();
      int  nxt;
      int  spent;
      bit  brq, lrq, all_new;
      cyc++;
      if (reset) begin
         model_clear();
         return;
      end
      nxt   = m_state;
      spent = cyc - enter;
      brq   = db || !t_s2;
      lrq   = !l_s2;
      case (m_state)
         0: if (!db && t_s2) nxt = 1;
         1: begin
            if (brq) nxt = 0;
            else if (l_s2) nxt = 2;
            else if (TimeoutEn && spent == int'(Lt)) begin
               nxt = 0;
               m_err = 1'b1;
            end
         end
         2: if (brq || lrq) nxt = 0; else if (spent == int'(Ph)) nxt = 3;
         3: if (brq || lrq) nxt = 0; else if (spent == int'(Cd)) nxt = 4;
         default: if (brq || lrq) nxt = 0;
      endcase
      if (m_state != 0 && nxt == 0) m_cause = !t_s2 ? 2 : (db ? 1 : 3);
      if (nxt != m_state) enter = cyc;
      m_state = nxt;
      hist.push_back(p_s2);
      void'(hist.pop_front());
      all_new = 1'b1;
      foreach (hist[i]) if (hist[i] == db) all_new = 1'b0;
      if (all_new) db = !db;
      p_s2 = p_s1; p_s1 = pad;
      t_s2 = t_s1; t_s1 = trst_n;
      l_s2 = l_s1; l_s1 = lock;
   endfunction

   task automatic step();
      logic [2:0] ms;
      logic [1:0] mc;
      logic [7:0] exp_v;
      @(posedge ref_clk);
      model_edge();
      #1;
      ms = m_state[2:0];
      mc = m_cause[1:0];
      exp_v = {ms, (m_state == 3 || m_state == 4), (m_state == 4), mc, m_err};
      check_eq($sformatf("cycle%0d", cyc), {24'b0, state, periph_n, pulp_n, cause, lock_err},
               {24'b0, exp_v});
   endtask

   task automatic wait_state(input int target, input int budget, input string tag);
      int n = 0;
      while (int'(state) != target && n < budget) begin
         step();
         n++;
      end
      check_eq(tag, {29'b0, state}, target);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      check_eq("reset_outputs_low", {30'b0, periph_n, pulp_n}, 0);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int n;
      int pad_hold, trst_hold, lock_hold;
      model_clear();

      // Power-up sequence
      repeat (4) step();
      check_eq("reset_state", {24'b0, state, periph_n, pulp_n, cause, lock_err}, 0);
      reset = 1'b0;
      repeat (15) step();
      lock = 1'b1;
      wait_state(2, 50, "enter_periph");
      t0 = cyc; n = 0;
      while (!periph_n && n < 200) begin step(); n++; end
      check_eq("periph_hold_len", cyc - t0, Ph);
      t0 = cyc; n = 0;
      while (!pulp_n && n < 200) begin step(); n++; end
      check_eq("core_delay_len", cyc - t0, Cd);
      check_eq("poweron_cause", {30'b0, cause}, 0);

      // Button glitch ignored, long press resets
      pad = 1'b1; repeat (10) step(); pad = 1'b0;
      repeat (30) step();
      check_eq("glitch_ignored", {29'b0, state}, 4);
      pad = 1'b1; repeat (20) step(); pad = 1'b0;
      wait_state(0, 20, "button_hold");
      check_eq("button_cause", {30'b0, cause}, 1);
      wait_state(4, 400, "reseq_after_button");

      // TRST and button together in CORE
      pulse_reset();
      wait_state(3, 400, "reach_core");
      trst_n = 1'b0; pad = 1'b1;
      wait_state(0, 10, "jtag_hold");
      repeat (2) step();
      trst_n = 1'b1; pad = 1'b0;
      check_eq("jtag_cause", {30'b0, cause}, 2);
      wait_state(4, 400, "reseq_after_jtag");

      // Lock drop seen exactly at the PERIPH terminal count
      pulse_reset();
      wait_state(2, 100, "reach_periph");
      t0 = cyc;
      while (cyc - t0 < 61) step();
      lock = 1'b0;
      repeat (3) step();
      check_eq("lockdrop_hold_not_core", {29'b0, state}, 0);
      check_eq("lockdrop_cause", {30'b0, cause}, 3);
      repeat (5) step();
      lock = 1'b1;
      wait_state(4, 400, "reseq_after_relock");

      // Lock held low for longer than the timeout
      lock = 1'b0;
      pulse_reset();
      repeat (Lt + 100) step();
      check_eq("lock_err_flag", {31'b0, lock_err}, {31'b0, TimeoutEn});
      check_eq("wait_lock_state", {29'b0, state}, m_state);
      lock = 1'b1;
      repeat (20) step();
      check_eq("lock_err_sticky", {31'b0, lock_err}, {31'b0, TimeoutEn});
      pulse_reset();
      check_eq("lock_err_cleared", {31'b0, lock_err}, 0);
      wait_state(4, 400, "run_after_timeout_test");

      // Random traffic
      pad_hold = 0; trst_hold = 0; lock_hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (pad_hold == 0) begin
            pad = ($urandom_range(0, 3) == 0);
            pad_hold = $urandom_range(1, 30);
         end else pad_hold--;
         if (trst_hold == 0) begin
            trst_n = ($urandom_range(0, 149) != 0);
            trst_hold = trst_n ? 0 : $urandom_range(1, 5);
         end else trst_hold--;
         if (lock_hold == 0) begin
            lock = ($urandom_range(0, 199) != 0);
            lock_hold = lock ? 0 : $urandom_range(1, 10);
         end else lock_hold--;
         reset = ($urandom_range(0, 999) == 0);
         step();
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
